// File: rtl/tr_stepgen_if.sv
// tr_stepgen_if: ADC-sample inputs and stepper-driver outputs of tr_stepgen
interface tr_stepgen_if #(
  parameter int IN_W  = 12,
  parameter int POS_W = 24
);
  logic data_valid;
  logic enable;
  logic [IN_W-1:0] x;
  logic [IN_W-1:0] x0;
  logic [IN_W-1:0] dx_near;
  logic [IN_W-1:0] dx_far;
  logic drv_step;
  logic drv_dir;
  logic drv_enable;
  logic [POS_W-1:0] pos;
  logic [1:0] state;
  modport master (
    output data_valid, enable, x, x0, dx_near, dx_far,
    input  drv_step, drv_dir, drv_enable, pos, state
  );
  modport slave (
    input  data_valid, enable, x, x0, dx_near, dx_far,
    output drv_step, drv_dir, drv_enable, pos, state
  );
endinterface

// File: rtl/tr_stepgen.sv
// tr_stepgen: tracking step generator driving step/dir/enable toward zero error with banded rates and hold hysteresis.
// Optional TR_ACCEL_EN: the step period ramps down from PER_NEAR by ACCEL_DEC per step.
module tr_stepgen #(
  parameter int IN_W      = 12,
  parameter int PER_W     = 17,
  parameter int PER_FAR   = 800,
  parameter int PER_MID   = 39600,
  parameter int PER_NEAR  = 80000,
  parameter int PULSE_W   = 50,
  parameter int DIR_SETUP = 100,
  parameter int HOLD_BAND = 0,
  parameter int DEADZONE  = 9,
  parameter int POS_W     = 24,
  parameter int ACCEL_DEC = 200
) (
  input logic clk,
  input logic rst_n,
  tr_stepgen_if.slave io
);
  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, HOLD = 2'd2} state_t;
  localparam logic [PER_W-1:0] ONE = PER_W'(1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  state_t st, st_d;
  logic dv_q, dir_req, step, dir, en;
  logic run, aligned, flip, start, step_d;
  logic [IN_W-1:0] err;
  logic [PER_W-1:0] cnt, cnt_d, per, per_new, sc, band;
  logic [POS_W-1:0] pos;

  if (PULSE_W >= PER_FAR || DEADZONE <= HOLD_BAND || DIR_SETUP < 1 || ACCEL_DEC < 0) begin : g_bad
    $error("tr_stepgen: inconsistent parameters");
  end

  always_comb begin
    st_d = st;
    if (!io.enable) st_d = IDLE;
    else if (st == IDLE) st_d = TRACK;
    else if (st == TRACK && err <= IN_W'(HOLD_BAND)) st_d = HOLD;
    else if (st == HOLD && err >= IN_W'(DEADZONE)) st_d = TRACK;
  end

  // A new pulse may only start at a period boundary, with the direction settled and its setup time spent
  always_comb begin
    band = err == '0 ? '0 : err >= io.dx_far ? PER_W'(PER_FAR) : err >= io.dx_near ? PER_W'(PER_MID) : PER_W'(PER_NEAR);
    run = st == TRACK && band != '0;
    aligned = dir == dir_req && sc == '0;
    flip = st == TRACK && !step && dir != dir_req;
    start = run && aligned && !step && (cnt == '0 || cnt == per - ONE);
    cnt_d = start ? '0 : (step || (run && aligned && cnt != '0)) ? cnt + ONE : '0;
    step_d = start || (step && cnt + ONE < PER_W'(PULSE_W));
  end

`ifdef TR_ACCEL_EN
  logic fresh;
  logic [PER_W-1:0] floor_p;
  always_comb begin
    floor_p = fresh ? PER_W'(PER_NEAR) : per > PER_W'(ACCEL_DEC) ? per - PER_W'(ACCEL_DEC) : '0;
    per_new = band > floor_p ? band : floor_p;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fresh <= 1'b1;
    else fresh <= st != TRACK || (fresh && !start);
`else
  assign per_new = band;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_d;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dv_q <= 1'b0;
      err <= '0;
      dir_req <= 1'b0;
      cnt <= '0;
      per <= '0;
      sc <= '0;
      step <= 1'b0;
      dir <= 1'b0;
      en <= 1'b0;
      pos <= '0;
    end else begin
      dv_q <= io.data_valid;
      if (io.data_valid && !dv_q) begin
        err <= io.x > io.x0 ? io.x - io.x0 : io.x0 - io.x;
        dir_req <= io.x <= io.x0;
      end
      cnt <= cnt_d;
      step <= step_d;
      if (start) per <= per_new;
      sc <= flip ? PER_W'(DIR_SETUP - 1) : sc != '0 ? sc - ONE : '0;
      if (flip) dir <= dir_req;
      en <= st == TRACK || (step && en);
      if (start) pos <= dir ? pos + POS_ONE : pos - POS_ONE;
    end

  assign io.drv_step = step;
  assign io.drv_dir = dir;
  assign io.drv_enable = en;
  assign io.pos = pos;
  assign io.state = st;
endmodule

// File: tb/tb_tr_stepgen.sv
// tb_tr_stepgen: expected step events are queued alongside the stimulus and matched on every drv_step rise
module tb_tr_stepgen;
  localparam int PULSE_W = 50;
  typedef struct {int gap; logic dir; logic [23:0] pos;} step_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_run = 0, n_fail = 0, cyc = 0, t_ref = 0, rise_cyc = 0;
  logic prev_step = 1'b0;
  step_t sb[$];

  tr_stepgen_if io();
  tr_stepgen #(.PER_MID(3000), .PER_NEAR(5000)) dut (.clk(clk), .rst_n(rst_n), .io(io));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic expect_step(input int gap, input logic dir, input logic [23:0] pos);
    step_t e;
    e.gap = gap;
    e.dir = dir;
    e.pos = pos;
    sb.push_back(e);
  endtask

  task automatic pulse_dv(input logic [11:0] a, input logic [11:0] b);
    io.x = a;
    io.x0 = b;
    io.data_valid = 1'b1;
    tick(1);
    io.data_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int b = budget;
    while (sb.size() != 0 && b > 0) begin
      tick(1);
      b--;
    end
    chk("sb_drain", 32'(sb.size()), 0);
  endtask

  task automatic outs(input string tag, input logic s, input logic d, input logic en, input logic [23:0] p, input logic [1:0] st);
    chk({tag, "_step"}, 32'(io.drv_step), 32'(s));
    chk({tag, "_dir"}, 32'(io.drv_dir), 32'(d));
    chk({tag, "_en"}, 32'(io.drv_enable), 32'(en));
    chk({tag, "_pos"}, 32'(io.pos), 32'(p));
    chk({tag, "_state"}, 32'(io.state), 32'(st));
  endtask

  always @(negedge clk) begin : mon
    step_t e;
    cyc++;
    if (!rst_n) prev_step = 1'b0;
    else begin
      if (io.drv_step && !prev_step) begin
        chk("step_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("step_gap", 32'(cyc - t_ref), 32'(e.gap));
          chk("step_dir", 32'(io.drv_dir), 32'(e.dir));
          chk("step_pos", 32'(io.pos), 32'(e.pos));
        end
        t_ref = cyc;
        rise_cyc = cyc;
      end
      if (!io.drv_step && prev_step) chk("pulse_width", 32'(cyc - rise_cyc), PULSE_W);
      prev_step = io.drv_step;
    end
  end

  initial begin
    io.data_valid = 1'b0;
    io.enable = 1'b0;
    io.x = 12'd500;
    io.x0 = 12'd100;
    io.dx_near = 12'd10;
    io.dx_far = 12'd100;
    #2 rst_n = 1'b0;
    tick(3);
    outs("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    pulse_dv(12'd500, 12'd100);
    tick(10000);
    outs("idle", 0, 0, 0, 0, 0);
    pulse_dv(12'd100, 12'd500);
    io.enable = 1'b1;
    t_ref = cyc + 1;
    expect_step(101, 1, 1);
    expect_step(800, 1, 2);
    expect_step(800, 1, 3);
    tick(1);
    chk("entry_state", 32'(io.state), 1);
    chk("entry_en_lag", 32'(io.drv_enable), 0);
    tick(1);
    chk("entry_en", 32'(io.drv_enable), 1);
    chk("entry_dir", 32'(io.drv_dir), 1);
    drain(3000);
    expect_step(800, 1, 4);
    expect_step(3000, 1, 5);
    pulse_dv(12'd100, 12'd150);
    drain(5000);
    expect_step(3000, 1, 6);
    expect_step(5000, 1, 7);
    pulse_dv(12'd100, 12'd105);
    drain(9000);
    pulse_dv(12'd100, 12'd100);
    tick(1);
    chk("hold_state", 32'(io.state), 2);
    chk("hold_pulse_on", 32'(io.drv_step), 1);
    chk("hold_en_on", 32'(io.drv_enable), 1);
    tick(49);
    chk("hold_pulse_off", 32'(io.drv_step), 0);
    chk("hold_en_off", 32'(io.drv_enable), 0);
    pulse_dv(12'd100, 12'd108);
    tick(2000);
    chk("hold_err8", 32'(io.state), 2);
    pulse_dv(12'd100, 12'd109);
    t_ref = cyc;
    expect_step(2, 1, 8);
    expect_step(5000, 1, 9);
    tick(1);
    chk("retrack_state", 32'(io.state), 1);
    drain(6000);
    expect_step(151, 0, 8);
    expect_step(5000, 0, 7);
    pulse_dv(12'd109, 12'd100);
    tick(48);
    chk("flip_pulse_on", 32'(io.drv_step), 1);
    chk("flip_dir_keep", 32'(io.drv_dir), 1);
    tick(1);
    chk("flip_pulse_off", 32'(io.drv_step), 0);
    chk("flip_dir_keep2", 32'(io.drv_dir), 1);
    tick(1);
    chk("flip_dir_new", 32'(io.drv_dir), 0);
    drain(6000);
    io.enable = 1'b0;
    tick(1);
    chk("dis_state", 32'(io.state), 0);
    chk("dis_pulse_on", 32'(io.drv_step), 1);
    chk("dis_en_on", 32'(io.drv_enable), 1);
    tick(50);
    chk("dis_pulse_off", 32'(io.drv_step), 0);
    chk("dis_en_off", 32'(io.drv_enable), 0);
    io.enable = 1'b1;
    t_ref = cyc;
    expect_step(2, 0, 6);
    drain(10);
    tick(10);
    rst_n = 1'b0;
    #1;
    outs("async_rst", 0, 0, 0, 0, 0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/tr_stepgen.md
# tr_stepgen

Parametrised tracking step generator: on each ADC sample it compares the measured position `x` with the table target `x0`. It drives a stepper driver (step/dir/enable) toward zero error using banded step rates, a hold deadzone with hysteresis, glitch-free pulses and direction setup time. It also keeps a signed step-position counter, and sits between the ADC reader and the stepper driver pins.

## Interface
- `IN_W`, 12: width of `x`, `x0`, `dx_near`, `dx_far` and of the internal error
- `PER_W`, 17: width of period counters
- `PER_FAR`, 800: clk cycles per step when err ≥ `dx_far`
- `PER_MID`, 39600: clk cycles per step when `dx_near` ≤ err < `dx_far`
- `PER_NEAR`, 80000: clk cycles per step when 0 < err < `dx_near`
- `PULSE_W`, 50: `drv_step` high time in clk cycles; must be < `PER_FAR`
- `DIR_SETUP`, 100: minimum cycles between a `drv_dir` change and the next step rising edge
- `HOLD_BAND`, 0: err ≤ this enters HOLD
- `DEADZONE`, 9: err ≥ this leaves HOLD; must be > `HOLD_BAND`
- `POS_W`, 24: width of `pos`
- `ACCEL_DEC`, 200: period decrement per step, used only with `TR_ACCEL_EN`
- `clk` in 1: system clock, 50 MHz
- `rst_n` in 1: asynchronous active-low reset
- `data_valid` in 1: ADC sample strobe, synchronous to `clk`
- `enable` in 1: tracking mode enable
- `x` in IN_W: measured position (unsigned)
- `x0` in IN_W: target position (unsigned)
- `dx_near` in IN_W: near band threshold
- `dx_far` in IN_W: far band threshold
- `drv_step` out 1: step pulse
- `drv_dir` out 1: direction; 1 when x ≤ x0
- `drv_enable` out 1: driver enable
- `pos` out POS_W: signed step count, two's complement
- `state` out 2: 0 IDLE, 1 TRACK, 2 HOLD

## Operation
- Reset: `drv_step` = 0, `drv_dir` = 0, `drv_enable` = 0, `pos` = 0, `state` = IDLE, latched error = 0, latched sign = 0, period counter = 0.
- **Sample capture**
  - On a rising edge of `data_valid` (1 while the previous cycle was 0), latch `err` = |x − x0| and `dir_req` = (x ≤ x0).
  - A level held high captures only once.
- **Band select** (combinational, from the latched `err`):
  - err ≥ `dx_far` → `PER_FAR`
  - else err ≥ `dx_near` → `PER_MID`
  - else err > 0 → `PER_NEAR`
  - err = 0 → no steps
  - If `dx_near` > `dx_far`, the far test wins.
- **State machine**
  - IDLE → TRACK when `enable` = 1.
  - TRACK → HOLD when err ≤ `HOLD_BAND`.
  - HOLD → TRACK when err ≥ `DEADZONE`.
  - TRACK/HOLD → IDLE when `enable` = 0. This has priority over all other transitions.
- **drv_enable**
  - Set on entry to TRACK.
  - Cleared on entry to HOLD or IDLE, but only once `drv_step` is low. An active pulse always completes its full `PULSE_W`; no runt pulses.
- **Step generation** (TRACK only)
  - The period counter counts from 0 to P−1. `drv_step` is high for counts 0..`PULSE_W`−1.
  - P is latched at count 0. A band change takes effect at the next step, never mid-period.
- **Direction**
  - `drv_dir` follows `dir_req` only while `drv_step` is low.
  - On any change of `drv_dir`, the period counter holds at 0 (no pulse) for `DIR_SETUP` cycles.
- **Position counter**
  - `pos` is incremented on each `drv_step` rising edge when `drv_dir` = 1, and decremented when `drv_dir` = 0.
  - It wraps modulo 2^POS_W.

## Timing
- `data_valid` edge at cycle n → `err`/`dir_req` valid at n+1 → state transition at n+2.
- TRACK entry at cycle t → `drv_enable` = 1 at t+1. The first `drv_step` rise is at t+1+`DIR_SETUP` if `drv_dir` changed, otherwise at t+1.
- Step rate is exactly one rising edge per P cycles in steady state.
- A direction request arriving mid-pulse is applied the cycle after `drv_step` falls. The setup wait starts from that cycle.
- `rst_n` low at any time, including mid-pulse: all outputs clear immediately (asynchronous); no pulse completion.

## Configuration
- `TR_ACCEL_EN` defined:
  - On TRACK entry, P starts at `PER_NEAR`.
  - Each step, P = max(band period, previous P − `ACCEL_DEC`).
  - A slower band applies immediately, with no deceleration ramp.
- `TR_ACCEL_EN` undefined: P = band period directly. `ACCEL_DEC` is ignored.

## Test plan
- Reset held, then released with `enable` = 0 and x = 500, x0 = 100 → all outputs 0, `state` = IDLE, no steps for 10000 cycles.
- `enable` = 1, x = 100, x0 = 500 (err 400, `dx_far` = 100) → `drv_dir` = 1, steps every 800 cycles each 50 high, `pos` +1 per step. Without `TR_ACCEL_EN`, first step at TRACK entry +1+100.
- err stepped 400 → 50 → 5 via successive `data_valid` (`dx_near` = 10) → periods 800, 39600, 80000, each applied from the next step boundary.
- err → 0 → HOLD, `drv_enable` low after the current pulse. err = 8 → stays in HOLD. err = 9 → TRACK.
- Sign flip delivered mid-pulse → pulse finishes at 50 cycles, `drv_dir` toggles next cycle, next rise ≥ 100 cycles later, `pos` direction reverses.
- `enable` dropped mid-pulse → pulse completes, then `drv_enable` = 0 and `state` = IDLE. `rst_n` asserted mid-pulse → `drv_step` = 0 immediately and `pos` = 0.
